// File: rtl/pic_rom_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pic_rom_pkg                                                  |
// | Description : Shared constants and types for the picture-ROM arbiter:      |
// |               address width, requester IDs, image geometry and the tag     |
// |               carried alongside each outstanding ROM read.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pic_rom_pkg;

    localparam int ADDR_W   = 18;
    localparam int N_REQ    = 3;

    // Requester IDs
    localparam int REQ_TOP  = 0;   // top banner scan, default priority
    localparam int REQ_SPR1 = 1;   // sprite/overlay renderer 1
    localparam int REQ_SPR2 = 2;   // sprite/overlay renderer 2

    // Picture geometry
    localparam int IMG_W    = 1440;
    localparam int TOP_H    = 100;

    typedef logic [1:0] req_id_t;

    // One outstanding read: which requester its data belongs to
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rom_tag_t;

endpackage : pic_rom_pkg
`default_nettype wire

// File: rtl/pic_rom_arbiter_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_tag_pipe                                                 |
// | Description : Shift register of {valid, requester ID} tags, DEPTH deep,    |
// |               aligned to the ROM read latency so that the tail stage       |
// |               flags which requester owns rom_dout this cycle.              |
// | Ports       : clk, rst      - clock, synchronous active-high reset         |
// |               tag_i         - tag of the read granted this cycle           |
// |               rvalid_o      - one-hot owner of the returning data          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rom_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  pic_rom_pkg::rom_tag_t           tag_i,
    output logic [pic_rom_pkg::N_REQ-1:0]   rvalid_o
);
    import pic_rom_pkg::*;

    rom_tag_t pipe_q [DEPTH];
    rom_tag_t tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Masking with rst keeps a read that reaches the tail during the reset
    // cycle itself from being reported.
    always_comb begin
        tail     = pipe_q[DEPTH-1];
        rvalid_o = '0;
        if (!rst && tail.valid) begin
            rvalid_o = N_REQ'(1) << tail.id;
        end
    end

endmodule : rom_tag_pipe
`default_nettype wire

// File: rtl/pic_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pic_rom_arbiter                                              |
// | Description : Three-way arbiter in front of a shared single-port 1-bit     |
// |               picture ROM. Requester 0 has priority; requesters 1/2 share  |
// |               round-robin and are protected from starvation by wait        |
// |               counters. One read per cycle, data returned in grant order.  |
// | Ports       : clk, rst             - clock, synchronous active-high reset  |
// |               req, addr0..2        - request vector and per-requester addr |
// |               gnt                  - one-hot combinational grant           |
// |               rvalid, rdata        - returned pixel and its owner          |
// |               rom_addr/en/dout     - shared ROM interface                  |
// |               starve               - requester 1/2 has waited MAX_WAIT     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pic_rom_arbiter #(
    parameter int ADDR_W   = pic_rom_pkg::ADDR_W,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [pic_rom_pkg::N_REQ-1:0]   req,
    input  logic [ADDR_W-1:0]               addr0,
    input  logic [ADDR_W-1:0]               addr1,
    input  logic [ADDR_W-1:0]               addr2,
    output logic [pic_rom_pkg::N_REQ-1:0]   gnt,
    output logic [pic_rom_pkg::N_REQ-1:0]   rvalid,
    output logic                            rdata,
    output logic [ADDR_W-1:0]               rom_addr,
    output logic                            rom_en,
    input  logic                            rom_dout,
    output logic [1:0]                      starve
);
    import pic_rom_pkg::*;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // Wait counters and starve flags, index 0 -> requester 1, index 1 -> requester 2
    logic [CNT_W-1:0]   wait_q [2];
    logic [CNT_W-1:0]   wait_d [2];
    // 1 when the most recent sprite grant went to requester 2
    logic               last2_q;
    logic               last2_d;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic               rom_en_q;
    logic               rom_en_d;

    logic [1:0]         spr_req;
    logic [1:0]         starved_req;
    logic               xfer;
    req_id_t            gnt_id;
    logic [ADDR_W-1:0]  gnt_addr;
    rom_tag_t           new_tag;

    // Two-way round-robin: on contention the one not served last wins
    function automatic logic [1:0] rr_pick(input logic [1:0] m, input logic last2);
        if (m == 2'b11) begin
            rr_pick = last2 ? 2'b01 : 2'b10;
        end else begin
            rr_pick = m;
        end
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            starve[k] = (wait_q[k] == CNT_W'(MAX_WAIT));
        end
    end

    // A starve flag may still be set in the cycle its requester withdraws,
    // so it only counts together with a live request.
    assign spr_req     = req[REQ_SPR2:REQ_SPR1];
    assign starved_req = starve & spr_req;

    always_comb begin
        gnt = '0;
        if (rst) begin
            gnt = '0;
        end else if (|starved_req) begin
            gnt = {rr_pick(starved_req, last2_q), 1'b0};
        end else if (req[REQ_TOP]) begin
            gnt = 3'b001;
        end else begin
            gnt = {rr_pick(spr_req, last2_q), 1'b0};
        end
    end

    assign xfer   = |gnt;
    // One-hot to binary for a 3-bit one-hot: bit 2 -> 2'b10, bit 1 -> 2'b01
    assign gnt_id = {gnt[REQ_SPR2], gnt[REQ_SPR1]};

    always_comb begin
        unique case (gnt_id)
            2'd1:    gnt_addr = addr1;
            2'd2:    gnt_addr = addr2;
            default: gnt_addr = addr0;
        endcase
    end

    always_comb begin
        rom_en_d   = xfer;
        rom_addr_d = xfer ? gnt_addr : rom_addr_q;

        last2_d = last2_q;
        if (gnt[REQ_SPR1]) begin
            last2_d = 1'b0;
        end else if (gnt[REQ_SPR2]) begin
            last2_d = 1'b1;
        end

        for (int k = 0; k < 2; k++) begin
            if (!req[k+1] || gnt[k+1]) begin
                wait_d[k] = '0;
            end else if (wait_q[k] != CNT_W'(MAX_WAIT)) begin
                wait_d[k] = wait_q[k] + CNT_W'(1);
            end else begin
                wait_d[k] = wait_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            last2_q    <= 1'b1;     // requester 1 wins the first contention
            wait_q[0]  <= '0;
            wait_q[1]  <= '0;
        end else begin
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            last2_q    <= last2_d;
            wait_q[0]  <= wait_d[0];
            wait_q[1]  <= wait_d[1];
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rdata    = rom_dout;

    // One stage for the address register plus ROM_LAT for the ROM itself
    assign new_tag.valid = xfer;
    assign new_tag.id    = gnt_id;

    rom_tag_pipe #(
        .DEPTH    (ROM_LAT + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_i    (new_tag),
        .rvalid_o (rvalid)
    );

endmodule : pic_rom_arbiter
`default_nettype wire

// File: tb/tb_pic_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pic_rom_arbiter                                           |
// | Description : Two arbiter builds (ROM_LAT 1 and 3) on shared stimulus,     |
// |               each with its own ROM model, checked against a behavioural   |
// |               per-cycle reference model.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pic_rom_arbiter;
    import pic_rom_pkg::*;

    localparam int MAXW = 15;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [2:0]        req = 3'b000;
    logic [ADDR_W-1:0] a0 = '0, a1 = '0, a2 = '0;

    logic [2:0]        gnt1, gnt3, rv1, rv3;
    logic              rd1, rd3, re1, re3, dout1, dout3;
    logic [ADDR_W-1:0] ra1, ra3;
    logic [1:0]        st1, st3;

    pic_rom_arbiter #(.ADDR_W(ADDR_W), .ROM_LAT(1), .MAX_WAIT(MAXW)) dut1 (
        .clk(clk), .rst(rst), .req(req), .addr0(a0), .addr1(a1), .addr2(a2),
        .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .rom_addr(ra1), .rom_en(re1),
        .rom_dout(dout1), .starve(st1));

    pic_rom_arbiter #(.ADDR_W(ADDR_W), .ROM_LAT(3), .MAX_WAIT(MAXW)) dut3 (
        .clk(clk), .rst(rst), .req(req), .addr0(a0), .addr1(a1), .addr2(a2),
        .gnt(gnt3), .rvalid(rv3), .rdata(rd3), .rom_addr(ra3), .rom_en(re3),
        .rom_dout(dout3), .starve(st3));

    // ROM contents: a scrambled bit per address
    function automatic logic pix(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E3779B1;
        return x[29] ^ x[17];
    endfunction

    // ROM models: address sampled on the edge, data ROM_LAT edges later
    logic       p1 = 1'b0;
    logic [2:0] p3 = 3'b000;
    always @(posedge clk) begin
        p1 <= re1 ? pix(ra1) : 1'b0;
        p3 <= {p3[1:0], (re3 ? pix(ra3) : 1'b0)};
    end
    assign dout1 = p1;
    assign dout3 = p3[2];

    // ---------------- reference model state ----------------
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                w1 = 0, w2 = 0;       // cycles each sprite requester has waited
    int                last_rr = 2;          // last sprite requester served
    bit                seen_rst = 0;
    bit                exp_en = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                g_prev = -1;
    bit                hv    [NCYC];         // transfer history by cycle
    int                hid   [NCYC];
    logic [ADDR_W-1:0] haddr [NCYC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sprite_rr(input bit c1, input bit c2);
        if (c1 && c2) return (last_rr == 2) ? 1 : 2;
        if (c1) return 1;
        if (c2) return 2;
        return -1;
    endfunction

    function automatic int model_pick(input logic [2:0] r);
        bit s1, s2;
        s1 = r[1] && (w1 == MAXW);
        s2 = r[2] && (w2 == MAXW);
        if (s1 || s2) return sprite_rr(s1, s2);
        if (r[0]) return REQ_TOP;
        return sprite_rr(r[1], r[2]);
    endfunction

    // Expected return for a build of latency lat in the current cycle: the
    // transfer made 1+lat cycles ago, if no reset has wiped it since.
    task automatic check_return(input int lat, input logic [2:0] rv, input logic rd);
        int idx;
        logic [2:0] erv;
        idx = cyc - 1 - lat;
        erv = 3'b000;
        if (!rst && idx >= 0 && hv[idx]) erv = 3'(1 << hid[idx]);
        check($sformatf("rvalid_lat%0d", lat), 32'(rv), 32'(erv));
        if (erv != 3'b000) check($sformatf("rdata_lat%0d", lat), 32'(rd), 32'(pix(haddr[idx])));
    endtask

    // One clock cycle: drive, settle, compare, advance the model
    task automatic step(input bit r, input logic [2:0] q,
                        input logic [ADDR_W-1:0] x0, x1, x2);
        int g;
        logic [2:0] eg;
        logic [ADDR_W-1:0] ga;
        @(posedge clk);
        #1;
        rst = r; req = q; a0 = x0; a1 = x1; a2 = x2;
        #3;
        g  = r ? -1 : model_pick(q);
        eg = (g < 0) ? 3'b000 : 3'(1 << g);
        ga = (g == 1) ? x1 : (g == 2) ? x2 : x0;
        check("gnt_lat1", 32'(gnt1), 32'(eg));
        check("gnt_lat3", 32'(gnt3), 32'(eg));
        check("gnt_onehot", 32'($onehot0(gnt1) && $onehot0(gnt3)), 32'd1);
        check_return(1, rv1, rd1);
        check_return(3, rv3, rd3);
        if (seen_rst) begin
            check("starve", 32'({st3, st1}),
                  32'({(w2 == MAXW), (w1 == MAXW), (w2 == MAXW), (w1 == MAXW)}));
            check("rom_en", 32'({re3, re1}), 32'({exp_en, exp_en}));
            check("rom_addr_lat1", 32'(ra1), 32'(exp_addr));
            check("rom_addr_lat3", 32'(ra3), 32'(exp_addr));
        end
        if (r) begin
            w1 = 0; w2 = 0; last_rr = 2;
            for (int i = cyc - 6; i < cyc; i++) if (i >= 0) hv[i] = 0;
            hv[cyc] = 0;
            exp_en = 0; exp_addr = '0; seen_rst = 1;
        end else begin
            hv[cyc] = (g >= 0); hid[cyc] = g; haddr[cyc] = ga;
            exp_en = (g >= 0);
            if (g >= 0) exp_addr = ga;
            w1 = (!q[1] || g == 1) ? 0 : ((w1 < MAXW) ? w1 + 1 : MAXW);
            w2 = (!q[2] || g == 2) ? 0 : ((w2 < MAXW) ? w2 + 1 : MAXW);
            if (g == 1 || g == 2) last_rr = g;
        end
        g_prev = g;
        cyc++;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    // Random traffic obeying the handshake: an ungranted request holds its
    // address, occasionally withdraws; a free requester asks with prob dens/4.
    task automatic rand_phase(input int n, input int dens);
        logic [2:0] q;
        logic [ADDR_W-1:0] x [3];
        q = 3'b000;
        for (int i = 0; i < 3; i++) x[i] = '0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (q[i] && g_prev != i) begin
                    if ($urandom_range(15) == 0) q[i] = 1'b0;
                end else begin
                    q[i] = ($urandom_range(3) < dens);
                    x[i] = ADDR_W'($urandom);
                end
            end
            step(($urandom_range(199) == 0), q, x[0], x[1], x[2]);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step(1, 3'b000, '0, '0, '0);
        // Single read at 0x005A0
        step(0, 3'b000, '0, '0, '0);
        step(0, 3'b001, 18'h005A0, '0, '0);
        repeat (5) step(0, 3'b000, 18'h005A0, '0, '0);
        // Full contention: starvation kicks in for 1 then 2
        for (int i = 0; i < 40; i++) step(0, 3'b111, ADDR_W'(i), 18'h1111, 18'h2222);
        // Round-robin between sprite requesters after reset
        repeat (2) step(1, 3'b000, '0, '0, '0);
        for (int i = 0; i < 6; i++) step(0, 3'b110, '0, ADDR_W'(100 + i), ADDR_W'(200 + i));
        // Streaming sweep of one image line by requester 0
        repeat (2) step(1, 3'b000, '0, '0, '0);
        for (int i = 0; i < IMG_W; i++) step(0, 3'b001, ADDR_W'(i), '0, '0);
        repeat (5) step(0, 3'b000, '0, '0, '0);
        // Reset while a read is in flight, then contention goes to requester 1
        step(0, 3'b001, 18'h00ABC, '0, '0);
        step(1, 3'b000, '0, '0, '0);
        repeat (3) step(0, 3'b000, '0, '0, '0);
        repeat (2) step(0, 3'b110, '0, 18'h00777, 18'h00888);
        repeat (5) step(0, 3'b000, '0, '0, '0);
        // Random traffic, dense then sparse
        rand_phase(1500, 3);
        rand_phase(1500, 1);
        repeat (5) step(0, 3'b000, '0, '0, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pic_rom_arbiter
`default_nettype wire
